// File: rtl/disp_scan_ctrl_if.sv
// rtl/disp_scan_ctrl_if.sv - control/data bundle between a display host and the scan controller
interface disp_scan_ctrl_if #(
  parameter int NUM_DIG = 4
);
  logic                   enable;
  logic                   load;
  logic [3*NUM_DIG-1:0]   codes_in;
  logic                   pending;
  logic [2:0]             col_code;
  logic [NUM_DIG-1:0]     dig_sel_n;
  logic                   blank;
  logic                   frame_done;

  modport master (
    output enable, load, codes_in,
    input  pending, col_code, dig_sel_n, blank, frame_done
  );

  modport slave (
    input  enable, load, codes_in,
    output pending, col_code, dig_sel_n, blank, frame_done
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - time-multiplexed letter display scan controller with frame-aligned code commit
module disp_scan_ctrl #(
  parameter int NUM_DIG = 4,
  parameter int DIV     = 50000,
  parameter int BLANK   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  disp_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BLNK, SHOW} state_t;

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = $clog2(NUM_DIG);
  localparam int CODES_W = 3 * NUM_DIG;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_C   = CW'(BLANK);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIG - 1);

  state_t               state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [SW-1:0]        slot, slot_d;
  logic [CODES_W-1:0]   active, active_d;
  logic [CODES_W-1:0]   shadow, shadow_d;
  logic                 pending_d;
  logic [2:0]           code_d;
  logic [NUM_DIG-1:0]   sel_n_d;
  logic                 frame_end;

  // Last cycle of the last slot: the only point where shadow codes may reach the active set
  assign frame_end = (state != IDLE) && (cnt == CNT_LAST) && (slot == SLOT_LAST);

  // Next-state, counters and the shadow/active code bookkeeping
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    slot_d    = slot;
    active_d  = active;
    shadow_d  = shadow;
    pending_d = bus.pending;

    if (!bus.enable) begin
      // Going dark: flush anything waiting so the next scan starts from the newest codes
      state_d   = IDLE;
      cnt_d     = '0;
      slot_d    = '0;
      if (bus.load)
        active_d = bus.codes_in;
      else if (bus.pending)
        active_d = shadow;
      pending_d = 1'b0;
    end else if (state == IDLE) begin
      cnt_d  = '0;
      slot_d = '0;
      if (bus.load)
        active_d = bus.codes_in;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt_d  = '0;
        slot_d = (slot == SLOT_LAST) ? '0 : slot + 1'b1;
      end else begin
        cnt_d = cnt + 1'b1;
      end

      if (frame_end) begin
        // A load on the boundary itself goes straight to the active set
        if (bus.load)
          active_d = bus.codes_in;
        else if (bus.pending)
          active_d = shadow;
        pending_d = 1'b0;
      end else if (bus.load) begin
        shadow_d  = bus.codes_in;
        pending_d = 1'b1;
      end
    end

    if (bus.enable)
      state_d = ((BLANK != 0) && (cnt_d < BLANK_C)) ? BLNK : SHOW;
  end

  // Output decode from the next-state values so the registered outputs line up with the state
  always_comb begin
    code_d  = '0;
    sel_n_d = '1;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (slot_d == SW'(i)) begin
        code_d = active_d[3*i +: 3];
        if (state_d == SHOW)
          sel_n_d[i] = 1'b0;
      end
    end
    if (state_d == IDLE)
      code_d = '0;
  end

  // Scan FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      slot           <= '0;
      active         <= '0;
      shadow         <= '0;
      bus.pending    <= 1'b0;
      bus.col_code   <= '0;
      bus.dig_sel_n  <= '1;
      bus.blank      <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      slot           <= slot_d;
      active         <= active_d;
      shadow         <= shadow_d;
      bus.pending    <= pending_d;
      bus.col_code   <= code_d;
      bus.dig_sel_n  <= sel_n_d;
      bus.blank      <= (state_d != SHOW);
      bus.frame_done <= (state_d != IDLE) && (cnt_d == CNT_LAST) && (slot_d == SLOT_LAST);
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - self-checking bench for disp_scan_ctrl against a time-based scan model
module tb_disp_scan_ctrl;
  localparam int ND = 4;
  localparam int DV = 8;
  localparam int BL = 2;
  localparam int FR = ND * DV;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  disp_scan_ctrl_if #(.NUM_DIG(ND)) bus ();

  disp_scan_ctrl #(.NUM_DIG(ND), .DIV(DV), .BLANK(BL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int fd_cnt  = 0;
  int fd_base = 0;
  bit chk_en  = 1'b0;

  // Model: scan position is just elapsed cycles since the scan started
  bit          m_run    = 1'b0;
  int          m_t      = 0;
  logic [11:0] m_active = '0;
  logic [11:0] m_shadow = '0;
  bit          m_pend   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic go(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run    <= 1'b0;
      m_t      <= 0;
      m_active <= '0;
      m_shadow <= '0;
      m_pend   <= 1'b0;
    end else if (!bus.enable) begin
      if (bus.load) m_active <= bus.codes_in;
      else if (m_pend) m_active <= m_shadow;
      m_pend <= 1'b0;
      m_run  <= 1'b0;
      m_t    <= 0;
    end else if (!m_run) begin
      if (bus.load) m_active <= bus.codes_in;
      m_run <= 1'b1;
      m_t   <= 0;
    end else begin
      if (m_t % FR == FR - 1) begin
        if (bus.load) m_active <= bus.codes_in;
        else if (m_pend) m_active <= m_shadow;
        m_pend <= 1'b0;
      end else if (bus.load) begin
        m_shadow <= bus.codes_in;
        m_pend   <= 1'b1;
      end
      m_t <= m_t + 1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      int ph, sl;
      logic [2:0] ec;
      logic [3:0] ed;
      logic eb, ef;
      ec = '0; ed = 4'hF; eb = 1'b1; ef = 1'b0;
      if (m_run) begin
        ph = m_t % DV;
        sl = (m_t / DV) % ND;
        ec = m_active[sl*3 +: 3];
        if (ph >= BL) begin
          ed = ~(4'b0001 << sl);
          eb = 1'b0;
        end
        ef = (m_t % FR) == FR - 1;
      end
      check("m_col_code", bus.col_code, ec);
      check("m_dig_sel_n", bus.dig_sel_n, ed);
      check("m_blank", bus.blank, eb);
      check("m_frame_done", bus.frame_done, ef);
      check("m_pending", bus.pending, m_pend);
      check("one_hot_low", $countones(~bus.dig_sel_n) <= 1, 1);
      if (bus.frame_done === 1'b1) fd_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable   = 1'b0;
    bus.load     = 1'b0;
    bus.codes_in = '0;
    #1 rst_n = 1'b0;
    go(3);
    chk_en = 1'b1;
    check("rst_dig", bus.dig_sel_n, 4'hF);
    check("rst_col", bus.col_code, 0);
    check("rst_blank", bus.blank, 1);
    check("rst_pend", bus.pending, 0);
    check("rst_fd", bus.frame_done, 0);
    rst_n = 1'b1;
    go(2);

    // 1: load in IDLE, basic scan
    bus.enable = 1'b1; bus.load = 1'b1; bus.codes_in = 12'o3210;
    go(1); bus.load = 1'b0;                       // t=0
    fd_base = fd_cnt;
    check("t1_blank0", bus.blank, 1);
    check("t1_dig0", bus.dig_sel_n, 4'hF);
    go(2);                                        // t=2
    check("t1_dig_s0", bus.dig_sel_n, 4'b1110);
    check("t1_col_s0", bus.col_code, 0);
    go(8);                                        // t=10
    check("t1_dig_s1", bus.dig_sel_n, 4'b1101);
    check("t1_col_s1", bus.col_code, 1);

    // 2: mid-frame load
    bus.load = 1'b1; bus.codes_in = 12'o5555;
    go(1); bus.load = 1'b0;                       // t=11
    check("t2_pend", bus.pending, 1);
    go(9);                                        // t=20
    check("t2_col_s2", bus.col_code, 2);
    check("t2_dig_s2", bus.dig_sel_n, 4'b1011);
    go(11);                                       // t=31
    check("t2_fd", bus.frame_done, 1);
    check("t2_col_s3", bus.col_code, 3);
    go(1);                                        // t=32
    check("t2_pend_clr", bus.pending, 0);
    check("t2_col_new", bus.col_code, 5);

    // 3: double load, last wins
    go(8);                                        // t=40
    bus.load = 1'b1; bus.codes_in = 12'o1111;
    go(1); bus.load = 1'b0;                       // t=41
    go(7);                                        // t=48
    bus.load = 1'b1; bus.codes_in = 12'o2222;
    go(1); bus.load = 1'b0;                       // t=49
    check("t3_pend", bus.pending, 1);
    go(15);                                       // t=64
    check("t3_col", bus.col_code, 2);
    check("t1_fd_count", fd_cnt - fd_base, 2);

    // 4: load on the frame_done cycle
    go(31);                                       // t=95
    check("t4_fd", bus.frame_done, 1);
    bus.load = 1'b1; bus.codes_in = 12'o7777;
    go(1); bus.load = 1'b0;                       // t=96
    check("t4_pend", bus.pending, 0);
    check("t4_col", bus.col_code, 7);

    // 5: enable dropped in slot 2 SHOW with a pending load
    go(4);                                        // t=100
    bus.load = 1'b1; bus.codes_in = 12'o4444;
    go(1); bus.load = 1'b0;                       // t=101
    check("t5_pend", bus.pending, 1);
    go(13);                                       // t=114
    check("t5_dig_s2", bus.dig_sel_n, 4'b1011);
    bus.enable = 1'b0;
    go(1);
    check("t5_dark_dig", bus.dig_sel_n, 4'hF);
    check("t5_dark_blank", bus.blank, 1);
    check("t5_dark_pend", bus.pending, 0);
    go(3);
    bus.enable = 1'b1;
    go(1);                                        // t=0
    check("t5_re_blank", bus.blank, 1);
    check("t5_re_col", bus.col_code, 4);
    go(2);                                        // t=2
    check("t5_re_dig", bus.dig_sel_n, 4'b1110);

    // 6: asynchronous reset mid-SHOW
    go(18);                                       // t=20
    check("t6_pre_col", bus.col_code, 4);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_dig", bus.dig_sel_n, 4'hF);
    check("t6_async_col", bus.col_code, 0);
    check("t6_async_blank", bus.blank, 1);
    go(2);
    rst_n = 1'b1;
    go(1);                                        // t=0
    go(10);                                       // t=10
    check("t6_dig_s1", bus.dig_sel_n, 4'b1101);
    check("t6_col_cleared", bus.col_code, 0);
    go(32);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
